seq_div_unit: RTL and testbench

- Iterative restoring divider; the inverse-operation companion to the team's N-bit carry look-ahead adder.
- Each iteration performs one trial subtraction (a + ~b + 1) through a CLA-style carry chain and produces one quotient bit per clock.
- Used by datapath blocks that need divide/modulo without a large combinational array.
- Simple start/ready/done handshake.

---
 rtl/seq_div_pkg.sv | 21 ++
 rtl/seq_div_sub_stage.sv | 34 +++
 rtl/seq_div_unit.sv | 151 +++++++++++++++
 tb/tb_seq_div_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// seq_div_pkg
// Shared types and constants for the sequential restoring divider.
//   state_t        : divider FSM states (IDLE, CALC, DONE)
//   cnt_width()    : width of the iteration counter for a given data width
//   DBZ_Q_BIT      : fill bit of the divide-by-zero quotient (all ones)
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold WIDTH-1 down to 0.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam logic DBZ_Q_BIT = 1'b1;

endpackage

// File: rtl/seq_div_sub_stage.sv
// div_sub_stage
// Combinational W-bit subtractor computing a + ~b + 1 with a
// generate/propagate carry chain.
// Ports:
//   a, b   : operands (W bits)
//   diff   : a - b modulo 2^W
//   borrow : 1 when a < b (carry out of the chain is clear)
module div_sub_stage #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W-1:0] gen;
  logic [W-1:0] prop;
  logic [W:0]   carry;

  // Subtraction as addition of the inverted subtrahend; the +1 enters as carry-in.
  always_comb begin
    gen      = a & ~b;
    prop     = a ^ ~b;
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < W; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
    diff   = prop ^ carry[W-1:0];
    borrow = ~carry[W];
  end

endmodule

// File: rtl/seq_div_unit.sv
// seq_div_unit
// Iterative restoring divider producing one quotient bit per clock.
// Optional macro SEQ_DIV_SIGNED_EN selects two's-complement operands
// (truncating division, remainder takes the dividend's sign).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : request, accepted only while ready=1
//   dividend, divisor   : operands, sampled on the accept edge
//   ready               : high only in IDLE
//   done                : one-cycle pulse when results are valid
//   quotient, remainder : results, held until the next result write
//   div_by_zero         : set with done when the divisor was 0
module seq_div_unit
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             unused_trial_msb;
  logic [WIDTH-1:0] next_rem;
  logic [WIDTH-1:0] next_quo;
  logic [WIDTH-1:0] final_quo;
  logic [WIDTH-1:0] final_rem;
  logic [WIDTH-1:0] op_dividend;
  logic [WIDTH-1:0] op_divisor;

  // {R,Q} shifted left by one: the dividend's next MSB moves into R.
  assign shifted = {rem_q, quo_q[WIDTH-1]};

  div_sub_stage #(.W(WIDTH + 1)) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs_q}),
    .diff   (trial),
    .borrow (borrow)
  );

  // When there is no borrow the trial result is below the divisor, so its MSB is always 0.
  assign unused_trial_msb = trial[WIDTH];

  always_comb begin
    next_rem = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    next_quo = {quo_q[WIDTH-2:0], ~borrow};
  end

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_quo;
  logic neg_rem;

  // The magnitude of MIN is MIN itself read as unsigned, which the core handles naturally.
  assign op_dividend = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
  assign op_divisor  = divisor[WIDTH-1]  ? (~divisor + WIDTH'(1))  : divisor;
  assign final_quo   = neg_quo ? (~next_quo + WIDTH'(1)) : next_quo;
  assign final_rem   = neg_rem ? (~next_rem + WIDTH'(1)) : next_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_quo <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_rem <= dividend[WIDTH-1];
    end
  end
`else
  assign op_dividend = dividend;
  assign op_divisor  = divisor;
  assign final_quo   = next_quo;
  assign final_rem   = next_rem;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ready       <= 1'b1;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ready <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= {WIDTH{DBZ_Q_BIT}};
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state       <= CALC;
              div_by_zero <= 1'b0;
              cnt         <= CW'(WIDTH - 1);
              rem_q       <= '0;
              quo_q       <= op_dividend;
              dvs_q       <= op_divisor;
            end
          end
        end
        CALC: begin
          rem_q <= next_rem;
          quo_q <= next_quo;
          cnt   <= cnt - CW'(1);
          // The last iteration's result goes straight to the outputs.
          if (cnt == '0) begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= final_quo;
            remainder <= final_rem;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_unit.sv
// tb_seq_div_unit
// Self-checking bench for seq_div_unit (WIDTH=8). Expected results come
// from plain integer division; SEQ_DIV_SIGNED_EN selects the signed model.
module tb_seq_div_unit;

  localparam int W = 8;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  seq_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference division straight from the arithmetic definition.
  function automatic void refDiv(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r,
                                 output logic z);
    z = (b == '0);
    if (b == '0) begin
      q = '1;
      r = a;
    end
`ifdef SEQ_DIV_SIGNED_EN
    else if (a == MINV && b == '1) begin
      q = MINV;
      r = '0;
    end else begin
      q = W'($signed(a) / $signed(b));
      r = W'($signed(a) % $signed(b));
    end
`else
    else begin
      q = a / b;
      r = a % b;
    end
`endif
  endfunction

  // One complete transaction: latency, results, single done pulse, ready return.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    int           k;
    refDiv(a, b, eq, er, ez);
    @(negedge clk);
    checkOutput("ready_idle", W'(ready), W'(1));
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("ready_drop", W'(ready), W'(0));
    k = 0;
    while (done !== 1'b1 && k < 4 * W) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    checkOutput("done_seen", W'(done), W'(1));
    checkOutput("latency", W'(k), ez ? W'(0) : W'(W));
    checkOutput("quotient", quotient, eq);
    checkOutput("remainder", remainder, er);
    checkOutput("div_by_zero", W'(div_by_zero), W'(ez));
    @(negedge clk);
    checkOutput("done_pulse", W'(done), W'(0));
    checkOutput("ready_back", W'(ready), W'(1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    logic [W-1:0] cap_q;
    logic [W-1:0] cap_r;
    int           ndone;

    // Reset state
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    checkOutput("rst_ready", W'(ready), W'(1));
    checkOutput("rst_done", W'(done), W'(0));
    checkOutput("rst_quotient", quotient, W'(0));
    checkOutput("rst_remainder", remainder, W'(0));
    checkOutput("rst_dbz", W'(div_by_zero), W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    applyStimulus(8'd200, 8'd7);
    applyStimulus(8'd5, 8'd0);
    applyStimulus(8'd7, 8'd9);
    applyStimulus(8'd255, 8'd1);
    applyStimulus(8'hF9, 8'd2);
    applyStimulus(8'd7, 8'hFE);
    applyStimulus(8'h80, 8'hFF);
    applyStimulus(8'h80, 8'd1);
    applyStimulus(8'd0, 8'd3);

    // Start during CALC is ignored; exactly one done for 100/3
    refDiv(8'd100, 8'd3, eq, er, ez);
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    cap_q = '0;
    cap_r = '0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          cap_q = quotient;
          cap_r = remainder;
        end
      end
    end
    checkOutput("ignore_done_count", W'(ndone), W'(1));
    checkOutput("ignore_quotient", cap_q, eq);
    checkOutput("ignore_remainder", cap_r, er);

    // Start held high across DONE is accepted in the first IDLE cycle
    refDiv(8'd60, 8'd7, eq, er, ez);
    @(negedge clk);
    dividend = 8'd60;
    divisor  = 8'd7;
    start    = 1'b1;
    ndone = 0;
    while (done !== 1'b1 && ndone < 4 * W) begin
      @(negedge clk);
      ndone++;
    end
    checkOutput("hold_done", W'(done), W'(1));
    @(negedge clk);
    checkOutput("hold_idle_ready", W'(ready), W'(1));
    @(negedge clk);
    start = 1'b0;
    checkOutput("hold_reaccept", W'(ready), W'(0));
    ndone = 0;
    while (done !== 1'b1 && ndone < 4 * W) begin
      @(negedge clk);
      ndone++;
    end
    checkOutput("hold_quotient", quotient, eq);
    checkOutput("hold_remainder", remainder, er);
    @(negedge clk);

    // Reset mid-CALC aborts with no done
    applyStimulus(8'd201, 8'd4);
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_ready", W'(ready), W'(1));
    checkOutput("abort_done", W'(done), W'(0));
    checkOutput("abort_quotient", quotient, W'(0));
    checkOutput("abort_remainder", remainder, W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checkOutput("abort_no_done", W'(ndone), W'(0));
    applyStimulus(8'd9, 8'd2);

    // Randomized operands, including zero and small divisors
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 4));
        default: rb = W'($urandom);
      endcase
      applyStimulus(ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
